ldpc_ber_tester_run_ctrl: RTL

Sequences one BER measurement run around the LDPC BER counter datapath.
- On start: clears the counter, then issues frame requests to the codeword source with a bounded number in flight.
- Counts decoded-frame completions and watches the counter's running bit-error total.
- Stops on frame budget, error target or abort, drains the pipeline, then latches final results for software.

---
 rtl/ldpc_ber_tester_run_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/ldpc_ber_tester_run_ctrl.sv
// Sequencer for one LDPC BER measurement run: clear counter, issue frames, stop, drain, latch results.
// Optional: define RUN_CTRL_CYCLE_COUNT_EN to add the saturating run_cycles output.
module ldpc_ber_tester_run_ctrl #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CLEAR_CYCLES    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] cfg_max_frames,
    input  logic [31:0] cfg_target_errors,
    output logic        frame_req_valid,
    input  logic        frame_req_ready,
    input  logic        frame_done,
    output logic        ber_resetn,
    input  logic        ber_active,
    input  logic [31:0] ber_bit_errors,
    output logic        busy,
    output logic        done,
    output logic [1:0]  stop_reason,
    output logic [31:0] frames_issued,
    output logic [31:0] frames_done,
    output logic [31:0] bit_errors_total,
    output logic        protocol_error
`ifdef RUN_CTRL_CYCLE_COUNT_EN
    ,
    output logic [47:0] run_cycles
`endif
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUTSTANDING);
    localparam logic [CLR_W-1:0] CLR_LOAD = CLR_W'(CLEAR_CYCLES - 1);

    localparam logic [1:0] RSN_NONE   = 2'd0;
    localparam logic [1:0] RSN_BUDGET = 2'd1;
    localparam logic [1:0] RSN_TARGET = 2'd2;
    localparam logic [1:0] RSN_ABORT  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

`ifdef RUN_CTRL_CYCLE_COUNT_EN
    function automatic logic [47:0] sat_inc48(input logic [47:0] v);
        return (&v) ? v : v + 48'd1;
    endfunction
`endif

    state_t           state, state_n;
    logic [CLR_W-1:0] clr_cnt, clr_cnt_n;
    logic [OUT_W-1:0] outstanding, outstanding_n;
    logic [31:0]      max_frames, max_frames_n;
    logic [31:0]      target_errors, target_errors_n;
    logic [31:0]      ber_errors_p0;

    logic             frame_req_valid_n;
    logic             busy_n;
    logic             done_n;
    logic [1:0]       stop_reason_n;
    logic [31:0]      frames_issued_n;
    logic [31:0]      frames_done_n;
    logic [31:0]      bit_errors_total_n;
    logic             protocol_error_n;

    logic start_ok, hs, fd_ok, fd_bad, hit_target, hit_budget;

    // ---- stage p0: error total registered before the stop compare
    always_ff @(posedge clk) begin
        ber_errors_p0 <= ber_bit_errors;
    end

    assign start_ok   = start && ((state == S_IDLE) || (state == S_DONE));
    assign hs         = frame_req_valid && frame_req_ready;
    assign fd_ok      = frame_done && (outstanding != '0);
    assign fd_bad     = frame_done && (outstanding == '0);
    assign hit_target = (target_errors != 32'd0) && (ber_errors_p0 >= target_errors);
    assign hit_budget = (frames_issued == max_frames);

    assign ber_resetn = !(reset || (state == S_CLEAR));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) state_n = S_CLEAR;
            end
            S_CLEAR: begin
                if (abort)                state_n = S_DRAIN;
                else if (clr_cnt == '0)   state_n = S_RUN;
            end
            S_RUN: begin
                if (abort || hit_target || hit_budget) state_n = S_DRAIN;
            end
            S_DRAIN: begin
                if ((outstanding == '0) && !ber_active) state_n = S_DONE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Next values of every registered output and counter; a start overrides the run-time updates.
    always_comb begin
        clr_cnt_n          = clr_cnt;
        max_frames_n       = max_frames;
        target_errors_n    = target_errors;
        outstanding_n      = outstanding;
        frames_issued_n    = frames_issued;
        frames_done_n      = frames_done;
        stop_reason_n      = stop_reason;
        bit_errors_total_n = bit_errors_total;
        protocol_error_n   = protocol_error | fd_bad;

        case ({hs, fd_ok})
            2'b10:   outstanding_n = outstanding + 1'b1;
            2'b01:   outstanding_n = outstanding - 1'b1;
            default: outstanding_n = outstanding;
        endcase

        if (hs)    frames_issued_n = sat_inc32(frames_issued);
        if (fd_ok) frames_done_n   = sat_inc32(frames_done);

        if ((state == S_CLEAR) && (clr_cnt != '0)) clr_cnt_n = clr_cnt - 1'b1;
        if ((state == S_CLEAR) && abort)           stop_reason_n = RSN_ABORT;

        if (state == S_RUN) begin
            if (abort)           stop_reason_n = RSN_ABORT;
            else if (hit_target) stop_reason_n = RSN_TARGET;
            else if (hit_budget) stop_reason_n = RSN_BUDGET;
        end

        if ((state == S_DRAIN) && (state_n == S_DONE)) bit_errors_total_n = ber_bit_errors;

        if (start_ok) begin
            clr_cnt_n        = CLR_LOAD;
            max_frames_n     = cfg_max_frames;
            target_errors_n  = cfg_target_errors;
            frames_issued_n  = '0;
            frames_done_n    = '0;
            stop_reason_n    = RSN_NONE;
            protocol_error_n = 1'b0;
        end

        frame_req_valid_n = (state_n == S_RUN) && (frames_issued_n < max_frames_n) &&
                            (outstanding_n < OUT_MAX);
        busy_n = (state_n == S_CLEAR) || (state_n == S_RUN) || (state_n == S_DRAIN);
        done_n = (state_n == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt          <= '0;
            max_frames       <= '0;
            target_errors    <= '0;
            outstanding      <= '0;
            frame_req_valid  <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            stop_reason      <= RSN_NONE;
            frames_issued    <= '0;
            frames_done      <= '0;
            bit_errors_total <= '0;
            protocol_error   <= 1'b0;
        end else begin
            clr_cnt          <= clr_cnt_n;
            max_frames       <= max_frames_n;
            target_errors    <= target_errors_n;
            outstanding      <= outstanding_n;
            frame_req_valid  <= frame_req_valid_n;
            busy             <= busy_n;
            done             <= done_n;
            stop_reason      <= stop_reason_n;
            frames_issued    <= frames_issued_n;
            frames_done      <= frames_done_n;
            bit_errors_total <= bit_errors_total_n;
            protocol_error   <= protocol_error_n;
        end
    end

`ifdef RUN_CTRL_CYCLE_COUNT_EN
    logic [47:0] run_cycles_n;

    always_comb begin
        run_cycles_n = run_cycles;
        if (start_ok)
            run_cycles_n = '0;
        else if ((state == S_CLEAR) || (state == S_RUN) || (state == S_DRAIN))
            run_cycles_n = sat_inc48(run_cycles);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_cycles <= '0;
        end else begin
            run_cycles <= run_cycles_n;
        end
    end
`endif

endmodule
